width_packer_n: RTL

- Parametrised narrow-to-wide packer for the PHY transmit path.
- Accepts IN_W-bit beats on clk_4f and assembles RATIO beats into one IN_W*RATIO word.
- Successor of the fixed 8-to-32 packer, with:
  - configurable beat width, ratio and lane order;
  - output back-pressure;
  - an explicit, selectable policy for words cut short by valid_in dropping.

---
 rtl/phy_pack_pkg.sv | 25 ++
 rtl/pack_out_reg.sv | 53 +++++
 rtl/width_packer_n.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/phy_pack_pkg.sv
`default_nettype none
// ============================================================================
// phy_pack_pkg : shared constants, state encoding and lane helper for the packer
// Rev 1.0
// ============================================================================
package phy_pack_pkg;

  localparam int ORDER_MSB_FIRST = 0;
  localparam int ORDER_LSB_FIRST = 1;
  localparam int PART_DISCARD    = 0;
  localparam int PART_FLUSH      = 1;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_FILL       = 2'd1,
    ST_FLUSH_PEND = 2'd2
  } pack_state_e;

  // Bit offset of beat k inside the packed word.
  function automatic int lane_off(int order, int ratio, int in_w, int k);
    return (order == ORDER_LSB_FIRST) ? k * in_w : (ratio - 1 - k) * in_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pack_out_reg.sv
`default_nettype none
// ============================================================================
// pack_out_reg : output holding register with valid/ready handshake
// Rev 1.0
// ============================================================================
module pack_out_reg #(
  parameter int W  = 32,
  parameter int LW = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic [W-1:0]  data_i,
  input  logic          partial_i,
  input  logic [LW-1:0] lanes_i,
  input  logic          ready_i,
  output logic [W-1:0]  data_o,
  output logic          valid_o,
  output logic          partial_o,
  output logic [LW-1:0] lanes_o,
  output logic          free_o
);

  logic [W-1:0]  data_q;
  logic          valid_q;
  logic          partial_q;
  logic [LW-1:0] lanes_q;

  assign free_o    = !valid_q || ready_i;
  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign partial_o = partial_q;
  assign lanes_o   = lanes_q;

  // A load always wins over a take on the same edge, keeping valid high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      partial_q <= 1'b0;
      lanes_q   <= '0;
    end else if (load_i) begin
      data_q    <= data_i;
      valid_q   <= 1'b1;
      partial_q <= partial_i;
      lanes_q   <= lanes_i;
    end else if (valid_q && ready_i) begin
      valid_q   <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/width_packer_n.sv
`default_nettype none
// ============================================================================
// width_packer_n : packs RATIO narrow beats into one wide word, with back-pressure
// Rev 1.0
// ============================================================================
module width_packer_n
  import phy_pack_pkg::*;
#(
  parameter int              IN_W         = 8,
  parameter int              RATIO        = 4,
  parameter int              ORDER        = ORDER_MSB_FIRST,
  parameter int              PARTIAL_MODE = PART_DISCARD,
  parameter logic [IN_W-1:0] PAD_VAL      = '0
) (
  input  logic                       clk_4f,
  input  logic                       reset_L,
  input  logic                       valid_in,
  input  logic [IN_W-1:0]            data_in,
  output logic                       in_ready,
  output logic [IN_W*RATIO-1:0]      data_out,
  output logic                       valid_out,
  input  logic                       out_ready,
  output logic                       partial_out,
  output logic [$clog2(RATIO+1)-1:0] lanes_out,
  output logic                       drop_err
);

  localparam int OUT_W = IN_W * RATIO;
  localparam int CW    = $clog2(RATIO);
  localparam int LW    = $clog2(RATIO + 1);
  localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

  pack_state_e      state_q;
  logic [CW-1:0]    cnt_q;
  logic [OUT_W-1:0] acc_q;
  logic             drop_err_q;

  logic             out_free;
  logic             accept;
  logic             last_beat;
  logic             flush_now;
  logic             load;
  logic [OUT_W-1:0] beat_word;
  logic [OUT_W-1:0] pad_word;
  logic [OUT_W-1:0] load_data;
  logic [LW-1:0]    load_lanes;

  assign in_ready  = (state_q != ST_FLUSH_PEND) && !((cnt_q == LAST) && !out_free);
  assign accept    = valid_in && in_ready;
  assign last_beat = accept && (cnt_q == LAST);
  assign flush_now = (PARTIAL_MODE == PART_FLUSH) && out_free &&
                     (((state_q == ST_FILL) && !valid_in) || (state_q == ST_FLUSH_PEND));
  assign load       = last_beat || flush_now;
  assign load_data  = last_beat ? beat_word : pad_word;
  assign load_lanes = last_beat ? LW'(RATIO) : LW'(cnt_q);

  // Accumulator with the current beat merged in, and with unfilled lanes padded.
  always_comb begin
    beat_word = acc_q;
    beat_word[lane_off(ORDER, RATIO, IN_W, int'(cnt_q)) +: IN_W] = data_in;
    pad_word = acc_q;
    for (int k = 0; k < RATIO; k++) begin
      if (k >= int'(cnt_q)) pad_word[lane_off(ORDER, RATIO, IN_W, k) +: IN_W] = PAD_VAL;
    end
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      drop_err_q <= 1'b0;
    end else begin
      drop_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            acc_q   <= beat_word;
            cnt_q   <= CW'(1);
            state_q <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (last_beat) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else if (accept) begin
            acc_q <= beat_word;
            cnt_q <= cnt_q + CW'(1);
          end else if (!valid_in) begin
            if (PARTIAL_MODE == PART_FLUSH) begin
              if (out_free) begin
                acc_q   <= '0;
                cnt_q   <= '0;
                state_q <= ST_IDLE;
              end else begin
                state_q <= ST_FLUSH_PEND;
              end
            end else begin
              acc_q      <= '0;
              cnt_q      <= '0;
              state_q    <= ST_IDLE;
              drop_err_q <= 1'b1;
            end
          end
        end
        ST_FLUSH_PEND: begin
          if (out_free) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          acc_q   <= '0;
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign drop_err = drop_err_q;

  pack_out_reg #(
    .W  (OUT_W),
    .LW (LW)
  ) u_out_reg (
    .clk_i     (clk_4f),
    .rst_ni    (reset_L),
    .load_i    (load),
    .data_i    (load_data),
    .partial_i (!last_beat),
    .lanes_i   (load_lanes),
    .ready_i   (out_ready),
    .data_o    (data_out),
    .valid_o   (valid_out),
    .partial_o (partial_out),
    .lanes_o   (lanes_out),
    .free_o    (out_free)
  );

endmodule
`default_nettype wire
